bin_to_bcd: RTL and testbench
=============================

// Module: bin_to_bcd
// PURPOSE
//  Iterative binary-to-packed-BCD converter (shift-add-3 / double dabble), one input bit per cycle.
//  Inverse path of the BCD-to-binary converter: converts binary results back to digits for ASCII output.
//  Valid/ready on both sides; accepts one word and holds the result until taken.
// PARAMETERS
//  BCD_DIGIT  8  number of BCD output digits (1..8); binary input width BIN_W = BCD_DIGIT*4
// PORTS
//  clk         input   1            rising-edge clock
//  rst_n       input   1            asynchronous active-low reset
//  in_valid    input   1            bin_in is valid
//  in_ready    output  1            converter idle, can accept bin_in
//  bin_in      input   BCD_DIGIT*4  unsigned binary operand
//  out_valid   output  1            bcd_out/overflow valid
//  out_ready   input   1            consumer takes result
//  bcd_out     output  BCD_DIGIT*4  packed BCD, digit 0 in [3:0]
//  overflow    output  1            bin_in >= 10**BCD_DIGIT
// BEHAVIOUR
//  Reset (rst_n low, async): state IDLE, in_ready=0, out_valid=0, bcd_out=0, overflow=0,
//   bit counter=0, shift registers=0. in_ready rises on the first clk edge after rst_n release.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: in_ready=1. Accept on edge where in_valid&&in_ready: capture bin_in into shift reg,
//   clear BCD accumulator and overflow, load counter=BIN_W, go SHIFT, in_ready->0.
//  SHIFT: each cycle, per digit: if digit>=5 add 3 (all digits in parallel, same cycle),
//   then shift {bcd_acc, bin_shift} left 1; bit leaving bcd_acc MSB ORs into overflow (sticky).
//   Counter decrements; on the edge performing the last (BIN_W-th) shift go DONE.
//  DONE: out_valid=1; bcd_out/overflow stable and unchanged while out_ready=0.
//   Edge with out_ready=1: out_valid->0, in_ready->1, go IDLE. bcd_out keeps last value.
//  Latency: out_valid is high exactly BIN_W edges after the accepting edge.
//  Throughput: one conversion per BIN_W+2 cycles min; no acceptance during SHIFT/DONE.
//  in_valid during SHIFT/DONE ignored (in_ready=0); bin_in only sampled on accepting edge.
//  Overflow: bcd_out = bin_in mod 10**BCD_DIGIT, overflow=1. Otherwise overflow=0.
//  All digits of bcd_out always in 0..9.
//  out_ready while out_valid=0 has no effect.
//  Reset mid-SHIFT or mid-DONE: conversion discarded, outputs to reset values immediately.
//  Counter width $clog2(BIN_W+1); no other arithmetic wider than 4 bits per digit.
// TESTING
//  bin_in=0 -> bcd_out=32'h00000000, overflow=0, out_valid exactly 32 edges after accept.
//  bin_in=12345678 -> bcd_out=32'h12345678, overflow=0.
//  bin_in=99999999 -> bcd_out=32'h99999999, overflow=0; bin_in=100000000 -> 32'h00000000, ovf=1.
//  bin_in=32'hFFFFFFFF (4294967295) -> bcd_out=32'h94967295, overflow=1.
//  out_ready low 5 cycles in DONE -> out_valid, bcd_out held, in_ready=0; in_valid pulses ignored.
//  rst_n low at 10th SHIFT cycle -> out_valid=0, bcd_out=0 async; next op 255 -> 32'h00000255.
//  BCD_DIGIT=2: bin_in=8'd99 -> 8'h99 ovf=0; bin_in=8'd255 -> 8'h55, ovf=1, latency 8.

Source files
------------

// File: rtl/bin_to_bcd.sv
// Iterative binary to packed-BCD converter (shift-add-3), one input bit per cycle,
// with valid/ready handshakes on both sides and a sticky overflow flag.
module bin_to_bcd #(
  parameter int BCD_DIGIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BCD_DIGIT*4-1:0] bin_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BCD_DIGIT*4-1:0] bcd_out,
  output logic                   overflow
);

  localparam int BIN_W = BCD_DIGIT * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_r, state_nx_s;
  logic               in_ready_r, in_ready_nx_s;
  logic               out_valid_r, out_valid_nx_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
  logic [BIN_W-1:0]   bin_r, bin_nx_s;
  logic [BIN_W-1:0]   acc_r, acc_nx_s;
  logic               ovf_acc_r, ovf_acc_nx_s;
  logic [BIN_W-1:0]   bcd_out_r, bcd_out_nx_s;
  logic               overflow_r, overflow_nx_s;
  logic [BIN_W-1:0]   adj_s;

  function automatic logic [3:0] add3(input logic [3:0] digit);
    if (digit >= 4'd5) begin
      return digit + 4'd3;
    end else begin
      return digit;
    end
  endfunction

  // Per-digit add-3 correction applied to the accumulator before each shift.
  always_comb begin
    adj_s = '0;
    for (int d = 0; d < BCD_DIGIT; d++) begin
      adj_s[d*4 +: 4] = add3(acc_r[d*4 +: 4]);
    end
  end

  // Next-state and next-output logic for the conversion sequencer.
  always_comb begin
    state_nx_s     = state_r;
    in_ready_nx_s  = in_ready_r;
    out_valid_nx_s = out_valid_r;
    cnt_nx_s       = cnt_r;
    bin_nx_s       = bin_r;
    acc_nx_s       = acc_r;
    ovf_acc_nx_s   = ovf_acc_r;
    bcd_out_nx_s   = bcd_out_r;
    overflow_nx_s  = overflow_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          bin_nx_s      = bin_in;
          acc_nx_s      = '0;
          ovf_acc_nx_s  = 1'b0;
          cnt_nx_s      = CNT_W'(BIN_W);
          in_ready_nx_s = 1'b0;
          state_nx_s    = ST_SHIFT;
        end else begin
          in_ready_nx_s = 1'b1;
        end
      end
      ST_SHIFT: begin
        // The bit pushed out of the top digit means the value reached 10**BCD_DIGIT.
        acc_nx_s     = {adj_s[BIN_W-2:0], bin_r[BIN_W-1]};
        bin_nx_s     = {bin_r[BIN_W-2:0], 1'b0};
        ovf_acc_nx_s = ovf_acc_r | adj_s[BIN_W-1];
        cnt_nx_s     = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          bcd_out_nx_s   = {adj_s[BIN_W-2:0], bin_r[BIN_W-1]};
          overflow_nx_s  = ovf_acc_r | adj_s[BIN_W-1];
          out_valid_nx_s = 1'b1;
          state_nx_s     = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_nx_s = 1'b0;
          in_ready_nx_s  = 1'b1;
          state_nx_s     = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s     = ST_IDLE;
        in_ready_nx_s  = 1'b0;
        out_valid_nx_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      cnt_r       <= '0;
      bin_r       <= '0;
      acc_r       <= '0;
      ovf_acc_r   <= 1'b0;
      bcd_out_r   <= '0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= in_ready_nx_s;
      out_valid_r <= out_valid_nx_s;
      cnt_r       <= cnt_nx_s;
      bin_r       <= bin_nx_s;
      acc_r       <= acc_nx_s;
      ovf_acc_r   <= ovf_acc_nx_s;
      bcd_out_r   <= bcd_out_nx_s;
      overflow_r  <= overflow_nx_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign bcd_out   = bcd_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Randomized bench for bin_to_bcd: 8-digit and 2-digit instances checked against
// an arithmetic decimal reference (mod / divide by ten).
module tb_bin_to_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv8, ir8, ov8, or8, ovf8;
  logic [31:0] bi8, bo8;
  logic        iv2, ir2, ov2, or2, ovf2;
  logic [7:0]  bi2, bo2;

  bin_to_bcd #(.BCD_DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .bin_in(bi8),
    .out_valid(ov8), .out_ready(or8), .bcd_out(bo8), .overflow(ovf8)
  );

  bin_to_bcd #(.BCD_DIGIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .bin_in(bi2),
    .out_valid(ov2), .out_ready(or2), .bcd_out(bo2), .overflow(ovf2)
  );

  int vectors = 0;
  int miscompares = 0;
  logic use2 = 1'b0;

  logic        cur_ir, cur_ov, cur_ovf;
  logic [63:0] cur_bcd;
  assign cur_ir  = use2 ? ir2 : ir8;
  assign cur_ov  = use2 ? ov2 : ov8;
  assign cur_ovf = use2 ? ovf2 : ovf8;
  assign cur_bcd = use2 ? {56'd0, bo2} : {32'd0, bo8};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Decimal reference: value modulo 10**nd, digits packed four bits each.
  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int nd, output logic ovf);
    longint unsigned lim;
    longint unsigned r;
    logic [63:0] res;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    ovf = (v >= lim);
    r = v % lim;
    res = '0;
    for (int i = 0; i < nd; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  task automatic drive_in(input logic v, input logic [31:0] d);
    if (use2) begin
      iv2 = v;
      bi2 = d[7:0];
    end else begin
      iv8 = v;
      bi8 = d;
    end
  endtask

  task automatic set_ordy(input logic v);
    if (use2) or2 = v;
    else      or8 = v;
  endtask

  task automatic convert(input logic [31:0] v, input int hold);
    int nd;
    int n;
    logic [63:0] exp;
    logic eovf;
    nd  = use2 ? 2 : 8;
    exp = ref_bcd(longint'(v), nd, eovf);
    n = 0;
    @(negedge clk);
    while (!cur_ir && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cur_ir) begin
      check("ready_timeout", 64'd0, 64'd1);
      return;
    end
    drive_in(1'b1, v);
    @(posedge clk);
    @(negedge clk);
    n = 0;
    // Random in_valid pulses while shifting must not disturb the conversion.
    while (!cur_ov && n < 100) begin
      drive_in(1'($urandom_range(0, 1)), $urandom);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    drive_in(1'b0, $urandom);
    check("latency", 64'(n), 64'(nd * 4));
    check("bcd", cur_bcd, exp);
    check("ovf", 64'(cur_ovf), 64'(eovf));
    for (int h = 0; h < hold; h++) begin
      drive_in(1'b1, $urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 64'(cur_ov), 64'd1);
      check("hold_bcd", cur_bcd, exp);
      check("hold_ovf", 64'(cur_ovf), 64'(eovf));
      check("hold_ready", 64'(cur_ir), 64'd0);
    end
    drive_in(1'b0, $urandom);
    set_ordy(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(1'b0);
    check("release_valid", 64'(cur_ov), 64'd0);
    check("release_ready", 64'(cur_ir), 64'd1);
    check("keep_bcd", cur_bcd, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    iv8 = 1'b0; bi8 = '0; or8 = 1'b0;
    iv2 = 1'b0; bi2 = '0; or2 = 1'b0;
    #12;
    check("rst_ready8", 64'(ir8), 64'd0);
    check("rst_valid8", 64'(ov8), 64'd0);
    check("rst_bcd8", {32'd0, bo8}, 64'd0);
    check("rst_ovf8", 64'(ovf8), 64'd0);
    check("rst_ready2", 64'(ir2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 64'(ir8), 64'd1);

    use2 = 1'b0;
    convert(32'd0, 0);
    convert(32'd12345678, 1);
    convert(32'd99999999, 0);
    convert(32'd100000000, 2);
    convert(32'hFFFFFFFF, 5);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) convert($urandom, int'($urandom_range(0, 3)));
      else convert(32'($urandom_range(0, 99999999)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a conversion.
    @(negedge clk);
    while (!ir8) @(negedge clk);
    drive_in(1'b1, 32'd87654321);
    @(posedge clk);
    @(negedge clk);
    drive_in(1'b0, 32'd0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(ov8), 64'd0);
    check("midrst_bcd", {32'd0, bo8}, 64'd0);
    check("midrst_ready", 64'(ir8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    convert(32'd255, 0);

    use2 = 1'b1;
    convert(32'd99, 0);
    convert(32'd255, 1);
    for (int i = 0; i < 15; i++) begin
      convert(32'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
